paddsb_accum_ctrl: RTL and testbench

Sequencing controller that drives the packed saturating nibble adder (four independent signed 4-bit lanes) as a multi-operand accumulator. A requester issues a start command with an operand count. The block accepts that many 16-bit operands over a valid/ready stream and folds each one into a running lane-wise saturating sum. It returns the final sum and sticky per-lane saturation flags over a second valid/ready handshake. It sits beside the ALU and serves as the reduction engine for packed-nibble instructions.

---
 rtl/paddsb_accum_ctrl_pkg.sv | 17 +
 rtl/paddsb_accum_ctrl_if.sv | 29 ++
 rtl/paddsb_accum_ctrl_nib_sat_add.sv | 23 ++
 rtl/paddsb_accum_ctrl.sv | 111 +++++++++++
 tb/tb_paddsb_accum_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/paddsb_accum_ctrl_pkg.sv
// Shared types and constants for the packed saturating nibble accumulator.
package paddsb_accum_ctrl_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = NIB_W * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [NIB_W-1:0] NIB_POS_SAT = 4'b0111;
  localparam logic [NIB_W-1:0] NIB_NEG_SAT = 4'b1000;

endpackage

// File: rtl/paddsb_accum_ctrl_if.sv
// Operand stream, result stream and job command bundle for the accumulator.
interface paddsb_accum_ctrl_if
  import paddsb_accum_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 4
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              op_valid;
  logic [DATA_W-1:0] op_data;
  logic              op_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [LANES-1:0]  res_sat;
  logic              res_ready;
  logic              busy;

  modport master (
    output start, len, op_valid, op_data, res_ready,
    input  op_ready, res_valid, res_data, res_sat, busy
  );

  modport slave (
    input  start, len, op_valid, op_data, res_ready,
    output op_ready, res_valid, res_data, res_sat, busy
  );

endinterface

// File: rtl/paddsb_accum_ctrl_nib_sat_add.sv
// Signed 4-bit saturating add for a single lane.
module nib_sat_add
  import paddsb_accum_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [NIB_W-1:0] y,
  output logic             ovf
);

  logic [NIB_W-1:0] s;

  always_comb begin
    s   = a + b;
    ovf = (a[NIB_W-1] == b[NIB_W-1]) && (s[NIB_W-1] != a[NIB_W-1]);
    y   = s;
    // Clamp direction follows the shared operand sign.
    if (ovf) begin
      y = a[NIB_W-1] ? NIB_NEG_SAT : NIB_POS_SAT;
    end
  end

endmodule

// File: rtl/paddsb_accum_ctrl.sv
// Multi-operand packed-nibble saturating accumulator with command, operand
// and result handshakes.
module paddsb_accum_ctrl
  import paddsb_accum_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 4
)(
  input logic                 clk,
  input logic                 rst,
  paddsb_accum_ctrl_if.slave  bus
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [LANES-1:0]  sat;
  logic [LEN_W-1:0]  remaining;
  logic              op_ready_q;
  logic              res_valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] res_data_q;
  logic [LANES-1:0]  res_sat_q;

  logic [DATA_W-1:0] sum_c;
  logic [LANES-1:0]  ovf_c;
  logic [LANES-1:0]  sat_nxt_c;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    nib_sat_add u_lane (
      .a   (acc[i*NIB_W +: NIB_W]),
      .b   (bus.op_data[i*NIB_W +: NIB_W]),
      .y   (sum_c[i*NIB_W +: NIB_W]),
      .ovf (ovf_c[i])
    );
  end

  assign sat_nxt_c = sat | ovf_c;

  // FSM plus datapath; handshake outputs are flops loaded with the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      sat         <= '0;
      remaining   <= '0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_data_q  <= '0;
      res_sat_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            sat    <= '0;
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              remaining  <= bus.len;
              state      <= ACCUM;
              op_ready_q <= 1'b1;
            end else begin
              state       <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
              res_sat_q   <= '0;
            end
          end
        end
        ACCUM: begin
          if (bus.op_valid && op_ready_q) begin
            acc       <= sum_c;
            sat       <= sat_nxt_c;
            remaining <= remaining - LEN_W'(1);
            // Result registers capture the final fold directly.
            if (remaining == LEN_W'(1)) begin
              state       <= DONE;
              op_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              res_data_q  <= sum_c;
              res_sat_q   <= sat_nxt_c;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
            res_sat_q   <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          op_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          res_data_q  <= '0;
          res_sat_q   <= '0;
        end
      endcase
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_sat   = res_sat_q;

endmodule

// File: tb/tb_paddsb_accum_ctrl.sv
// Directed bench with a job-level reference model checked every cycle.
module tb_paddsb_accum_ctrl;
  import paddsb_accum_ctrl_pkg::*;

  localparam int unsigned LEN_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  paddsb_accum_ctrl_if #(.LEN_W(LEN_W)) bus ();

  paddsb_accum_ctrl #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lane add in plain signed integers, clamped to [-8, 7].
  function automatic void ref_add(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] ov);
    r  = '0;
    ov = '0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] na;
      logic [3:0] nb;
      int t;
      na = a[i*4 +: 4];
      nb = b[i*4 +: 4];
      t  = int'($signed(na)) + int'($signed(nb));
      if (t > 7) begin
        t = 7;
        ov[i] = 1'b1;
      end else if (t < -8) begin
        t = -8;
        ov[i] = 1'b1;
      end
      r[i*4 +: 4] = 4'(t);
    end
  endfunction

  // Job-level model: 0 = waiting for command, 1 = taking operands, 2 = presenting.
  int          m_mode  = 0;
  int          m_left  = 0;
  int          m_taken = 0;
  logic [15:0] m_acc   = '0;
  logic [3:0]  m_sat   = '0;
  bit          chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      m_left = 0;
      m_acc  = '0;
      m_sat  = '0;
      chk_en = 1'b1;
    end else begin
      case (m_mode)
        0: if (bus.start) begin
          m_acc = '0;
          m_sat = '0;
          if (bus.len == '0) m_mode = 2;
          else begin
            m_left = int'(bus.len);
            m_mode = 1;
          end
        end
        1: if (bus.op_valid) begin
          logic [15:0] r;
          logic [3:0]  ov;
          ref_add(m_acc, bus.op_data, r, ov);
          m_acc = r;
          m_sat = m_sat | ov;
          m_taken++;
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
        default: if (bus.res_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("op_ready", 16'(bus.op_ready), 16'(m_mode == 1));
      check("res_valid", 16'(bus.res_valid), 16'(m_mode == 2));
      check("busy", 16'(bus.busy), 16'(m_mode != 0));
      check("res_data", bus.res_data, (m_mode == 2) ? m_acc : 16'h0000);
      check("res_sat", 16'(bus.res_sat), (m_mode == 2) ? 16'(m_sat) : 16'h0000);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ops [3];

  task automatic do_job(input string name, input int n, input int gap, input int hold,
                        input bit pulse_start, input bit start_on_hs,
                        input logic [15:0] exp_d, input logic [3:0] exp_s);
    int k = 0;
    int guard = 0;
    int idle_left = 0;
    int cnt = 0;
    int taken0;
    logic accepted;
    logic [15:0] first_d;
    taken0 = m_taken;
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
    check({name, ":op_ready_after_start"}, 16'(bus.op_ready), 16'(n != 0));
    while (k < n && guard < 200) begin
      guard++;
      if (idle_left > 0) begin
        bus.op_valid = 1'b0;
        idle_left--;
        if (pulse_start) begin
          bus.start = 1'b1;
          bus.len   = LEN_W'(2);
        end
      end else begin
        bus.op_valid = 1'b1;
        bus.op_data  = ops[k];
      end
      accepted = bus.op_valid && bus.op_ready;
      tick();
      bus.start = 1'b0;
      bus.len   = '0;
      if (accepted) begin
        k++;
        idle_left = gap;
      end
    end
    bus.op_valid = 1'b0;
    bus.op_data  = '0;
    check({name, ":operands_taken"}, 16'(k), 16'(n));
    check({name, ":latency"}, 16'(bus.res_valid), 16'h0001);
    guard = 0;
    while (!bus.res_valid && guard < 50) begin
      guard++;
      tick();
    end
    check({name, ":res_data"}, bus.res_data, exp_d);
    check({name, ":res_sat"}, 16'(bus.res_sat), 16'(exp_s));
    check({name, ":model_acc"}, m_acc, exp_d);
    first_d = bus.res_data;
    bus.res_ready = 1'b0;
    repeat (hold) begin
      if (bus.res_valid) cnt++;
      check({name, ":hold_stable"}, bus.res_data, first_d);
      tick();
    end
    bus.res_ready = 1'b1;
    if (start_on_hs) begin
      bus.start = 1'b1;
      bus.len   = LEN_W'(1);
    end
    if (bus.res_valid) cnt++;
    tick();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    check({name, ":valid_cycles"}, 16'(cnt), 16'(hold + 1));
    check({name, ":idle_after_hs"}, 16'(bus.busy), 16'h0000);
    check({name, ":consumed"}, 16'(m_taken - taken0), 16'(n));
    tick();
    check({name, ":still_idle"}, 16'(bus.busy), 16'h0000);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset:busy", 16'(bus.busy), 16'h0000);
    check("reset:op_ready", 16'(bus.op_ready), 16'h0000);
    check("reset:res_valid", 16'(bus.res_valid), 16'h0000);
    check("reset:res_data", bus.res_data, 16'h0000);
    check("reset:res_sat", 16'(bus.res_sat), 16'h0000);
    tick();

    ops[0] = 16'h1234; ops[1] = 16'h1111; ops[2] = 16'h0000;
    do_job("plain", 2, 0, 0, 1'b0, 1'b1, 16'h2345, 4'b0000);

    ops[0] = 16'h7777; ops[1] = 16'h1111;
    do_job("pos_sat", 2, 0, 0, 1'b0, 1'b0, 16'h7777, 4'b1111);

    ops[0] = 16'h8000; ops[1] = 16'h8000; ops[2] = 16'h7000;
    do_job("neg_sat_sticky", 3, 0, 0, 1'b0, 1'b0, 16'hF000, 4'b1000);

    do_job("len_zero", 0, 0, 0, 1'b0, 1'b0, 16'h0000, 4'b0000);

    ops[0] = 16'hF001; ops[1] = 16'hF002; ops[2] = 16'h0FF3;
    do_job("gaps_backpressure", 3, 2, 3, 1'b1, 1'b0, 16'hEFF6, 4'b0000);

    // Abandon a job mid-stream with reset.
    bus.start = 1'b1;
    bus.len   = LEN_W'(3);
    tick();
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.op_valid = 1'b1;
    bus.op_data  = 16'h2222;
    tick();
    bus.op_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset:busy", 16'(bus.busy), 16'h0000);
    check("midreset:op_ready", 16'(bus.op_ready), 16'h0000);
    check("midreset:res_valid", 16'(bus.res_valid), 16'h0000);
    tick();

    ops[0] = 16'h0123;
    do_job("after_reset", 1, 0, 0, 1'b0, 1'b0, 16'h0123, 4'b0000);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
